// File: rtl/demux_1x2_32_32.sv
// 1-to-2 valid/ready demultiplexer with a one-word holding register per channel.
// Build option DEMUX_HOLD_LAST_EN: keep the last word on OutN after consume (else clear to 0).
module demux_1x2_32_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In,
  input  logic        Sel,
  input  logic        InValid,
  output logic        InReady,
  output logic [31:0] Out0,
  output logic [31:0] Out1,
  output logic        Out0Valid,
  output logic        Out1Valid,
  input  logic        Out0Ready,
  input  logic        Out1Ready
);

  logic [31:0] out0_q, out0_d;
  logic [31:0] out1_q, out1_d;
  logic        out0_valid_q, out0_valid_d;
  logic        out1_valid_q, out1_valid_d;

  logic        sel0_s, sel1_s;
  logic        in_ready_s;
  logic        load0_s, load1_s;
  logic        take0_s, take1_s;

  // Select decode and handshake; an unknown Sel addresses no channel, so nothing is accepted.
  always_comb begin
    sel0_s     = (Sel === 1'b0);
    sel1_s     = (Sel === 1'b1);
    in_ready_s = 1'b0;
    if (sel0_s) begin
      in_ready_s = !out0_valid_q || Out0Ready;
    end else if (sel1_s) begin
      in_ready_s = !out1_valid_q || Out1Ready;
    end else begin
      in_ready_s = 1'b0;
    end
    load0_s = InValid && sel0_s && in_ready_s;
    load1_s = InValid && sel1_s && in_ready_s;
    take0_s = out0_valid_q && Out0Ready;
    take1_s = out1_valid_q && Out1Ready;
  end

  // Next state of channel 0: refill wins over consume so a coincident pair loses no cycle.
  always_comb begin
    out0_d       = out0_q;
    out0_valid_d = out0_valid_q;
    if (load0_s) begin
      out0_d       = In;
      out0_valid_d = 1'b1;
    end else if (take0_s) begin
`ifdef DEMUX_HOLD_LAST_EN
      out0_d       = out0_q;
`else
      out0_d       = 32'h0000_0000;
`endif
      out0_valid_d = 1'b0;
    end else begin
      out0_d       = out0_q;
      out0_valid_d = out0_valid_q;
    end
  end

  // Next state of channel 1, same rules as channel 0.
  always_comb begin
    out1_d       = out1_q;
    out1_valid_d = out1_valid_q;
    if (load1_s) begin
      out1_d       = In;
      out1_valid_d = 1'b1;
    end else if (take1_s) begin
`ifdef DEMUX_HOLD_LAST_EN
      out1_d       = out1_q;
`else
      out1_d       = 32'h0000_0000;
`endif
      out1_valid_d = 1'b0;
    end else begin
      out1_d       = out1_q;
      out1_valid_d = out1_valid_q;
    end
  end

  // Channel registers; reset overrides any accept or consume on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      out0_q       <= 32'h0000_0000;
      out1_q       <= 32'h0000_0000;
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
    end else begin
      out0_q       <= out0_d;
      out1_q       <= out1_d;
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
    end
  end

  assign InReady   = in_ready_s;
  assign Out0      = out0_q;
  assign Out1      = out1_q;
  assign Out0Valid = out0_valid_q;
  assign Out1Valid = out1_valid_q;

endmodule

// File: tb/tb_demux_1x2_32_32.sv
// Self-checking bench for demux_1x2_32_32: directed scenarios plus a queue-based scoreboard stream.
// Honours DEMUX_HOLD_LAST_EN for the post-consume data expectation.
module tb_demux_1x2_32_32;

`ifdef DEMUX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] In;
  logic        Sel;
  logic        InValid;
  logic        InReady;
  logic [31:0] Out0, Out1;
  logic        Out0Valid, Out1Valid;
  logic        Out0Ready, Out1Ready;

  int checks = 0;
  int failures = 0;

  demux_1x2_32_32 dut (
    .clk(clk), .reset(reset), .In(In), .Sel(Sel), .InValid(InValid), .InReady(InReady),
    .Out0(Out0), .Out1(Out1), .Out0Valid(Out0Valid), .Out1Valid(Out1Valid),
    .Out0Ready(Out0Ready), .Out1Ready(Out1Ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    In = 32'h0; Sel = 1'b0; InValid = 1'b0; Out0Ready = 1'b0; Out1Ready = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic s, input logic [31:0] d);
    In = d; Sel = s; InValid = 1'b1; Out0Ready = 1'b0; Out1Ready = 1'b0;
    tick();
    InValid = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    In = 32'h5555_AAAA; InValid = 1'b1; Sel = 1'b1;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; idle_inputs();
    #1;
    checks++; if (Out0 !== 32'h0) begin failures++; $display("FAIL reset_out0 got=%h exp=%h", Out0, 32'h0); end
    checks++; if (Out1 !== 32'h0) begin failures++; $display("FAIL reset_out1 got=%h exp=%h", Out1, 32'h0); end
    checks++; if (Out0Valid !== 1'b0) begin failures++; $display("FAIL reset_v0 got=%b exp=0", Out0Valid); end
    checks++; if (Out1Valid !== 1'b0) begin failures++; $display("FAIL reset_v1 got=%b exp=0", Out1Valid); end
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", InReady); end
  endtask

  task automatic test_route_hold();
    apply_reset();
    In = 32'hDEAD_BEEF; Sel = 1'b1; InValid = 1'b1; Out1Ready = 1'b0; Out0Ready = 1'b0;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL route_inready got=%b exp=1", InReady); end
    tick();
    In = 32'h1234_5678;
    #1;
    checks++; if (Out1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL route_out1 got=%h exp=deadbeef", Out1); end
    checks++; if (Out1Valid !== 1'b1) begin failures++; $display("FAIL route_v1 got=%b exp=1", Out1Valid); end
    checks++; if (Out0Valid !== 1'b0) begin failures++; $display("FAIL route_v0 got=%b exp=0", Out0Valid); end
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL full_inready got=%b exp=0", InReady); end
    tick();
    checks++; if (Out1 !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hold_out1 got=%h exp=deadbeef", Out1); end
    InValid = 1'b0; Out1Ready = 1'b1;
    tick();
    Out1Ready = 1'b0;
    checks++; if (Out1Valid !== 1'b0) begin failures++; $display("FAIL drain_v1 got=%b exp=0", Out1Valid); end
    checks++; if (Out1 !== (HOLD ? 32'hDEAD_BEEF : 32'h0)) begin failures++; $display("FAIL drain_out1 got=%h exp=%h", Out1, (HOLD ? 32'hDEAD_BEEF : 32'h0)); end
  endtask

  task automatic test_refill();
    apply_reset();
    load(1'b0, 32'h1);
    In = 32'h2; Sel = 1'b0; InValid = 1'b1; Out0Ready = 1'b1;
    #1;
    checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL refill_inready got=%b exp=1", InReady); end
    checks++; if (Out0 !== 32'h1) begin failures++; $display("FAIL refill_pre_out0 got=%h exp=1", Out0); end
    tick();
    InValid = 1'b0; Out0Ready = 1'b0;
    checks++; if (Out0 !== 32'h2) begin failures++; $display("FAIL refill_out0 got=%h exp=2", Out0); end
    checks++; if (Out0Valid !== 1'b1) begin failures++; $display("FAIL refill_v0 got=%b exp=1", Out0Valid); end
  endtask

  task automatic test_cross();
    apply_reset();
    load(1'b1, 32'hA);
    In = 32'hB; Sel = 1'b0; InValid = 1'b1; Out1Ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (Out0 !== 32'hB) begin failures++; $display("FAIL cross_out0 got=%h exp=b", Out0); end
    checks++; if (Out0Valid !== 1'b1) begin failures++; $display("FAIL cross_v0 got=%b exp=1", Out0Valid); end
    checks++; if (Out1Valid !== 1'b0) begin failures++; $display("FAIL cross_v1 got=%b exp=0", Out1Valid); end
    checks++; if (Out1 !== (HOLD ? 32'hA : 32'h0)) begin failures++; $display("FAIL cross_out1 got=%h exp=%h", Out1, (HOLD ? 32'hA : 32'h0)); end
  endtask

  task automatic test_reset_priority();
    apply_reset();
    load(1'b0, 32'h1111_1111);
    load(1'b1, 32'h2222_2222);
    reset = 1'b1; In = 32'h3333_3333; Sel = 1'b0; InValid = 1'b1; Out0Ready = 1'b1;
    tick();
    reset = 1'b0; idle_inputs();
    checks++; if (Out0Valid !== 1'b0 || Out1Valid !== 1'b0) begin failures++; $display("FAIL rstpri_valids got=%b%b exp=00", Out0Valid, Out1Valid); end
    checks++; if (Out0 !== 32'h0 || Out1 !== 32'h0) begin failures++; $display("FAIL rstpri_outs got=%h/%h exp=0/0", Out0, Out1); end
  endtask

  task automatic test_sel_x();
    apply_reset();
    load(1'b0, 32'h0000_00C0);
    load(1'b1, 32'h0000_00C1);
    In = 32'hFFFF_FFFF; Sel = 1'bx; InValid = 1'b1;
    #1;
    checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL selx_inready got=%b exp=0", InReady); end
    tick();
    idle_inputs();
    checks++; if (Out0 !== 32'hC0 || Out0Valid !== 1'b1) begin failures++; $display("FAIL selx_ch0 got=%h/%b exp=c0/1", Out0, Out0Valid); end
    checks++; if (Out1 !== 32'hC1 || Out1Valid !== 1'b1) begin failures++; $display("FAIL selx_ch1 got=%h/%b exp=c1/1", Out1, Out1Valid); end
  endtask

  // Random traffic: accepted words are queued per channel and popped when consumed.
  task automatic test_scoreboard();
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] tail0, tail1, w;
    logic        exp_rdy, acc, c0, c1;
    apply_reset();
    tail0 = 32'h0; tail1 = 32'h0;
    for (int n = 0; n < 400; n++) begin
      In = $urandom; Sel = 1'($urandom_range(0, 1)); InValid = 1'($urandom_range(0, 2) != 0);
      Out0Ready = 1'($urandom_range(0, 2) == 0); Out1Ready = 1'($urandom_range(0, 2) == 0);
      #1;
      exp_rdy = Sel ? (q1.size() == 0 || Out1Ready) : (q0.size() == 0 || Out0Ready);
      checks++; if (InReady !== exp_rdy) begin failures++; $display("FAIL sb_inready n=%0d got=%b exp=%b", n, InReady, exp_rdy); end
      acc = InValid && exp_rdy;
      c0 = (q0.size() != 0) && Out0Ready;
      c1 = (q1.size() != 0) && Out1Ready;
      w = In;
      tick();
      if (c0) begin tail0 = q0.pop_front(); if (!HOLD) tail0 = 32'h0; end
      if (c1) begin tail1 = q1.pop_front(); if (!HOLD) tail1 = 32'h0; end
      if (acc && !Sel) q0.push_back(w);
      if (acc && Sel) q1.push_back(w);
      checks++; if (Out0Valid !== (q0.size() != 0) || Out0 !== ((q0.size() != 0) ? q0[0] : tail0)) begin
        failures++; $display("FAIL sb_ch0 n=%0d got=%h/%b exp=%h/%b", n, Out0, Out0Valid, ((q0.size() != 0) ? q0[0] : tail0), (q0.size() != 0)); end
      checks++; if (Out1Valid !== (q1.size() != 0) || Out1 !== ((q1.size() != 0) ? q1[0] : tail1)) begin
        failures++; $display("FAIL sb_ch1 n=%0d got=%h/%b exp=%h/%b", n, Out1, Out1Valid, ((q1.size() != 0) ? q1[0] : tail1), (q1.size() != 0)); end
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_route_hold();
    test_refill();
    test_cross();
    test_reset_priority();
    test_sel_x();
    test_scoreboard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_1x2_32_32.md
DEMUX_1X2_32_32 -- requirements
Module: demux_1x2_32_32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port In, input, 32 bits: data word to be routed.
REQ-004 SHALL have port Sel, input, 1 bit: destination select; 0 routes to channel 0, 1 routes to channel 1.
REQ-005 SHALL have port InValid, input, 1 bit: In/Sel carry a word to transfer.
REQ-006 SHALL have port InReady, output, 1 bit: block accepts the word this cycle.
REQ-007 SHALL have ports Out0 and Out1, output, 32 bits each: held word of channel 0 and channel 1.
REQ-008 SHALL have ports Out0Valid and Out1Valid, output, 1 bit each: the channel holds an unconsumed word.
REQ-009 SHALL have ports Out0Ready and Out1Ready, input, 1 bit each: the consumer takes the channel word this cycle.

Function
REQ-010 SHALL provide one 32-bit holding register plus one valid flag per channel.
REQ-011 SHALL accept an input transfer on a rising edge where InValid=1 and InReady=1.
REQ-012 SHALL drive InReady = !OutSelValid || OutSelReady, where OutSel is the channel addressed by Sel; this is a combinational path from OutNReady to InReady.
REQ-013 SHALL, on an accepted transfer, load In into the selected channel register and set its valid at that edge, giving 1-cycle latency; the unselected channel is unchanged.
REQ-014 SHALL clear OutNValid on an edge where OutNValid=1 and OutNReady=1, unless the same edge refills channel N.
REQ-015 SHALL, when refill and consume coincide on one channel, present the new word with OutNValid still 1, losing no cycle and no word.
REQ-016 SHALL operate the two channels independently: a consume on one channel and an accept to the other in the same cycle both take effect.
REQ-017 SHALL hold OutN stable while OutNValid=1 and OutNReady=0, regardless of In, Sel, or InValid.
REQ-018 SHALL drive InReady=0 and load nothing when Sel is x or z and InValid=1.
REQ-019 SHALL ignore In and Sel when InValid=0; InReady then still reflects the Sel-addressed channel.
REQ-020 SHALL leave OutN data and OutNValid unaffected by OutNReady while OutNValid=0.

Reset
REQ-021 SHALL, on a rising edge with reset=1, set Out0=Out1=32'h0 and Out0Valid=Out1Valid=0.
REQ-022 SHALL give reset priority over any simultaneous accept or consume; a word pending or offered during reset is dropped.
REQ-023 SHALL drive InReady=1 in the first cycle after reset is released.

Configuration
REQ-024 SHALL use the macro DEMUX_HOLD_LAST_EN to select post-consume data behaviour.
REQ-025 SHALL, with DEMUX_HOLD_LAST_EN defined, keep OutN at the last loaded word after it is consumed.
REQ-026 SHALL, without DEMUX_HOLD_LAST_EN, clear OutN to 32'h0 on the edge where it is consumed without a refill; valid-flag and handshake behaviour are identical in both builds.

Verification
REQ-027 SHALL cover: reset asserted, then released -> Out0=Out1=0, both valids 0, InReady=1.
REQ-028 SHALL cover: In=32'hDEADBEEF, Sel=1, InValid=1 for one cycle, Out1Ready=0 -> next cycle Out1=DEADBEEF, Out1Valid=1, Out0Valid=0; then Sel=1, InValid=1 -> InReady=0 and Out1 stays DEADBEEF.
REQ-029 SHALL cover: channel 0 holds 32'h1, Out0Ready=1, In=32'h2, Sel=0, InValid=1 -> InReady=1, next cycle Out0=2, Out0Valid=1.
REQ-030 SHALL cover: channel 1 holds 32'hA, Out1Ready=1, In=32'hB, Sel=0, InValid=1 -> next cycle Out0=B with Out0Valid=1, Out1Valid=0, and Out1=A with the macro defined or 0 without it.
REQ-031 SHALL cover: both channels valid, reset=1 together with InValid=1 -> next cycle both valids 0, both outputs 0, no load.
REQ-032 SHALL cover: Sel=x, InValid=1 -> InReady=0 and both channels unchanged.
